// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic engine arbiter: op codes and FSM state encoding.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer, pointer
// advances past the served requester when upd is pulsed.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            upd,
    input  logic [NREQ-1:0] served,
    output logic [NREQ-1:0] gnt,
    output logic            any
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (served[i]) ptr_d = PW'((i + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/arith_unit_arbiter.sv
// Shares one iterative add/sub engine between NREQ requesters; mul by repeated
// addition, div by repeated subtraction, results returned with a done pulse.
module arith_unit_arbiter
    import arith_pkg::*;
#(
    parameter int W    = 8,
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op_i,
    input  logic [W*NREQ-1:0] a_i,
    input  logic [W*NREQ-1:0] b_i,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [2*W-1:0]    result,
    output logic [W-1:0]      rem_o,
    output logic              dbz,
    output logic              busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic [2*W-1:0]    result_q, result_d, acc_q, acc_d;
    logic [W-1:0]      rem_q, rem_d, a_q, a_d, b_q, b_d, cnt_q, cnt_d, r_q, r_d;
    logic              dbz_q, dbz_d;
    logic [1:0]        op_q, op_d;

    logic [NREQ-1:0]   arb_gnt;
    logic              arb_any, arb_upd;
    logic [IW-1:0]     gidx;
    logic [2*W-1:0]    eng_x, eng_y, eng_sum;
    logic              eng_sub;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .upd    (arb_upd),
        .served (gnt_q),
        .gnt    (arb_gnt),
        .any    (arb_any)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) gidx = IW'(i);
        end
    end

    // Single shared adder/subtractor; operand routing depends on the latched op.
    always_comb begin
        eng_x   = {{W{1'b0}}, a_q};
        eng_y   = {{W{1'b0}}, b_q};
        eng_sub = 1'b0;
        case (op_q)
            OP_SUB: eng_sub = 1'b1;
            OP_MUL: begin
                eng_x = acc_q;
                eng_y = {{W{1'b0}}, a_q};
            end
            OP_DIV: begin
                eng_x   = {{W{1'b0}}, r_q};
                eng_sub = 1'b1;
            end
            default: ;
        endcase
        eng_sum = eng_x + (eng_y ^ {(2*W){eng_sub}}) + {{(2*W-1){1'b0}}, eng_sub};
    end

    always_comb begin
        logic           fin;
        logic [2*W-1:0] fin_res;
        logic [W-1:0]   fin_rem;
        logic           fin_dbz;
        fin      = 1'b0;
        fin_res  = '0;
        fin_rem  = '0;
        fin_dbz  = 1'b0;
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        arb_upd  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                op_d    = op_i[2*gidx +: 2];
                a_d     = a_i[W*gidx +: W];
                b_d     = b_i[W*gidx +: W];
                r_d     = a_i[W*gidx +: W];
                acc_d   = '0;
                cnt_d   = '0;
                arb_upd = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        fin     = 1'b1;
                        fin_res = eng_sum;
                    end
                    OP_MUL: begin
                        if (b_q == '0) begin
                            fin = 1'b1;
                        end else begin
                            acc_d = eng_sum;
                            cnt_d = cnt_q + W'(1);
                            if (cnt_q + W'(1) == b_q) begin
                                fin     = 1'b1;
                                fin_res = eng_sum;
                            end
                        end
                    end
                    default: begin
                        if (b_q == '0) begin
                            fin     = 1'b1;
                            fin_rem = r_q;
                            fin_dbz = 1'b1;
                        end else if (r_q >= b_q) begin
                            r_d   = eng_sum[W-1:0];
                            acc_d = acc_q + (2*W)'(1);
                        end else begin
                            fin     = 1'b1;
                            fin_res = acc_q;
                            fin_rem = r_q;
                        end
                    end
                endcase
                if (fin) begin
                    done_d   = gnt_q;
                    result_d = fin_res;
                    rem_d    = fin_rem;
                    dbz_d    = fin_dbz;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            r_q      <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign rem_o  = rem_q;
    assign dbz    = dbz_q;
    assign busy   = (state_q != ST_IDLE);

endmodule
